// File: rtl/rx_symbol_detector.sv
// rx_symbol_detector: integrates strobe-high windows of channel samples, removes the noise offset
// and slices each window into a ternary symbol with a one-cycle valid pulse and running counts.
module rx_symbol_detector #(
    parameter int MAX_SAMPLES = 64,
    parameter int MIN_SAMPLES = 2,
    parameter int BIAS        = 128,
    parameter int THRESH      = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_start,
    input  logic signed [13:0] rx_in,
    output logic [1:0]         rx_sym,
    output logic               rx_valid,
    output logic               rx_short,
    output logic [15:0]        sym_count,
    output logic [15:0]        short_count
);
    localparam int CW = $clog2(MAX_SAMPLES) + 1;
    localparam int AW = 14 + CW;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_SAMPLES);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_SAMPLES);

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           sym_q, sym_d;
    logic                 valid_q, valid_d;
    logic                 short_q, short_d;
    logic [15:0]          sym_cnt_q, sym_cnt_d;
    logic [15:0]          short_cnt_q, short_cnt_d;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] thr;

    // the sized cast of the signed sample sign-extends before the offset is removed
    assign term = AW'(rx_in) - AW'(BIAS);
    assign thr  = $signed(AW'(THRESH) * {{(AW-CW){1'b0}}, cnt_q});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sym_q       <= '0;
            valid_q     <= 1'b0;
            short_q     <= 1'b0;
            sym_cnt_q   <= '0;
            short_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sym_q       <= sym_d;
            valid_q     <= valid_d;
            short_q     <= short_d;
            sym_cnt_q   <= sym_cnt_d;
            short_cnt_q <= short_cnt_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE)  ? (rx_start ? ACCUM : IDLE) :
                  (state_q == ACCUM) ? (rx_start ? ACCUM : DECIDE) : IDLE;
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sym_d       = sym_q;
        valid_d     = 1'b0;
        short_d     = short_q;
        sym_cnt_d   = sym_cnt_q;
        short_cnt_d = short_cnt_q;
        if (state_q == IDLE && rx_start) begin
            acc_d = term;
            cnt_d = CW'(1);
        end else if (state_q == ACCUM && rx_start && cnt_q < MAX_C) begin
            acc_d = acc_q + term;
            cnt_d = cnt_q + CW'(1);
        end else if (state_q == DECIDE) begin
            valid_d   = 1'b1;
            sym_cnt_d = sym_cnt_q + 16'd1;
            short_d   = cnt_q < MIN_C;
            if (cnt_q < MIN_C) begin
                sym_d       = 2'b00;
                short_cnt_d = short_cnt_q + 16'd1;
            end else begin
                sym_d = (acc_q > thr) ? 2'b01 : (acc_q < -thr) ? 2'b11 : 2'b00;
            end
        end
    end

    assign rx_sym      = sym_q;
    assign rx_valid    = valid_q;
    assign rx_short    = short_q;
    assign sym_count   = sym_cnt_q;
    assign short_count = short_cnt_q;
endmodule

// File: tb/tb_rx_symbol_detector.sv
// tb_rx_symbol_detector: directed checks of windowing, slicing, short windows,
// saturation, async reset and back-to-back windows.
module tb_rx_symbol_detector;
    logic               clk = 1'b0;
    logic               reset;
    logic               rx_start;
    logic signed [13:0] rx_in;
    logic [1:0]         rx_sym;
    logic               rx_valid;
    logic               rx_short;
    logic [15:0]        sym_count;
    logic [15:0]        short_count;
    int                 errors = 0;
    int                 checks = 0;
    int                 pulses = 0;

    rx_symbol_detector dut (
        .clk(clk), .reset(reset), .rx_start(rx_start), .rx_in(rx_in),
        .rx_sym(rx_sym), .rx_valid(rx_valid), .rx_short(rx_short),
        .sym_count(sym_count), .short_count(short_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_valid) pulses++;

    // drives n strobe-high samples, then one low; returns #1 after the edge following the fall edge
    task automatic drive_window(input logic signed [13:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            rx_start = 1'b1;
            rx_in    = v;
            @(posedge clk); #1;
        end
        rx_start = 1'b0;
        rx_in    = 14'sd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; rx_start = 1'b0; rx_in = 14'sd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rx_sym !== 2'b00) begin errors++; $display("FAIL reset_sym got=%b exp=00", rx_sym); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_short !== 1'b0) begin errors++; $display("FAIL reset_short got=%b exp=0", rx_short); end
        checks++; if (sym_count !== 16'd0) begin errors++; $display("FAIL reset_sym_count got=%0d exp=0", sym_count); end
        checks++; if (short_count !== 16'd0) begin errors++; $display("FAIL reset_short_count got=%0d exp=0", short_count); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_positive;
        pulses = 0;
        drive_window(14'sd563, 8);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got=%b exp=1", rx_valid); end
        checks++; if (rx_sym !== 2'b01) begin errors++; $display("FAIL t1_sym got=%b exp=01", rx_sym); end
        checks++; if (rx_short !== 1'b0) begin errors++; $display("FAIL t1_short got=%b exp=0", rx_short); end
        checks++; if (sym_count !== 16'd1) begin errors++; $display("FAIL t1_sym_count got=%0d exp=1", sym_count); end
        @(posedge clk); #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_drop got=%b exp=0", rx_valid); end
        checks++; if (rx_sym !== 2'b01) begin errors++; $display("FAIL t1_sym_hold got=%b exp=01", rx_sym); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL t1_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_negative_and_threshold;
        drive_window(-14'sd307, 8);
        checks++; if (rx_sym !== 2'b11) begin errors++; $display("FAIL t2_neg_sym got=%b exp=11", rx_sym); end
        checks++; if (sym_count !== 16'd2) begin errors++; $display("FAIL t2_neg_count got=%0d exp=2", sym_count); end
        @(posedge clk); #1;
        drive_window(14'sd328, 8);
        checks++; if (rx_sym !== 2'b00) begin errors++; $display("FAIL t2_pos_edge_sym got=%b exp=00", rx_sym); end
        @(posedge clk); #1;
        drive_window(14'sd329, 8);
        checks++; if (rx_sym !== 2'b01) begin errors++; $display("FAIL t2_pos_above_sym got=%b exp=01", rx_sym); end
        @(posedge clk); #1;
        drive_window(-14'sd72, 8);
        checks++; if (rx_sym !== 2'b00) begin errors++; $display("FAIL t2_neg_edge_sym got=%b exp=00", rx_sym); end
        checks++; if (sym_count !== 16'd5) begin errors++; $display("FAIL t2_count got=%0d exp=5", sym_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_short;
        drive_window(14'sd8191, 1);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL t3_valid got=%b exp=1", rx_valid); end
        checks++; if (rx_sym !== 2'b00) begin errors++; $display("FAIL t3_sym got=%b exp=00", rx_sym); end
        checks++; if (rx_short !== 1'b1) begin errors++; $display("FAIL t3_short got=%b exp=1", rx_short); end
        checks++; if (short_count !== 16'd1) begin errors++; $display("FAIL t3_short_count got=%0d exp=1", short_count); end
        checks++; if (sym_count !== 16'd6) begin errors++; $display("FAIL t3_sym_count got=%0d exp=6", sym_count); end
        @(posedge clk); #1;
        checks++; if (rx_short !== 1'b1) begin errors++; $display("FAIL t3_short_hold got=%b exp=1", rx_short); end
        drive_window(14'sd563, 2);
        checks++; if (rx_short !== 1'b0 || rx_sym !== 2'b01) begin errors++; $display("FAIL t3_min_window got=%b/%b exp=0/01", rx_short, rx_sym); end
        checks++; if (short_count !== 16'd1) begin errors++; $display("FAIL t3_short_count_keep got=%0d exp=1", short_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation;
        pulses = 0;
        drive_window(14'sd563, 100);
        checks++; if (rx_sym !== 2'b01) begin errors++; $display("FAIL t4_sym got=%b exp=01", rx_sym); end
        @(posedge clk); #1;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL t4_pulses got=%0d exp=1", pulses); end
        // 64 samples of +201 clear 64*200; the 36 large negatives after saturation must be ignored
        for (int i = 0; i < 100; i++) begin
            rx_start = 1'b1;
            rx_in    = (i < 64) ? 14'sd329 : -14'sd872;
            @(posedge clk); #1;
        end
        rx_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (rx_sym !== 2'b01) begin errors++; $display("FAIL t4_sat_hold_sym got=%b exp=01", rx_sym); end
        checks++; if (sym_count !== 16'd9) begin errors++; $display("FAIL t4_sym_count got=%0d exp=9", sym_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_window;
        for (int i = 0; i < 4; i++) begin
            rx_start = 1'b1;
            rx_in    = 14'sd563;
            @(posedge clk);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (rx_sym !== 2'b00 || rx_valid !== 1'b0 || rx_short !== 1'b0) begin errors++; $display("FAIL t5_async_outs got=%b/%b/%b exp=00/0/0", rx_sym, rx_valid, rx_short); end
        checks++; if (sym_count !== 16'd0 || short_count !== 16'd0) begin errors++; $display("FAIL t5_async_counts got=%0d/%0d exp=0/0", sym_count, short_count); end
        #1 reset = 1'b0; rx_start = 1'b0;
        pulses = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL t5_no_partial got=%0d exp=0", pulses); end
        drive_window(-14'sd307, 8);
        checks++; if (rx_valid !== 1'b1 || rx_sym !== 2'b11) begin errors++; $display("FAIL t5_sym got=%b/%b exp=1/11", rx_valid, rx_sym); end
        checks++; if (sym_count !== 16'd1) begin errors++; $display("FAIL t5_sym_count got=%0d exp=1", sym_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic signed [13:0] v [3];
        logic [1:0]         e [3];
        v = '{14'sd563, 14'sd128, -14'sd307};
        e = '{2'b01, 2'b00, 2'b11};
        pulses = 0;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 8; i++) begin
                rx_start = 1'b1;
                rx_in    = v[w];
                @(posedge clk); #1;
                if (w > 0 && i == 0) begin
                    checks++; if (rx_valid !== 1'b1 || rx_sym !== e[w-1]) begin errors++; $display("FAIL t6_win%0d got=%b/%b exp=1/%b", w - 1, rx_valid, rx_sym, e[w-1]); end
                end
                if (w > 0 && i == 1) begin
                    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL t6_drop%0d got=%b exp=0", w - 1, rx_valid); end
                end
            end
            rx_start = 1'b0;
            @(posedge clk); #1;
            checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL t6_early%0d got=%b exp=0", w, rx_valid); end
        end
        @(posedge clk); #1;
        checks++; if (rx_valid !== 1'b1 || rx_sym !== 2'b11) begin errors++; $display("FAIL t6_win2 got=%b/%b exp=1/11", rx_valid, rx_sym); end
        @(posedge clk); #1;
        checks++; if (pulses !== 3) begin errors++; $display("FAIL t6_pulses got=%0d exp=3", pulses); end
        checks++; if (sym_count !== 16'd4) begin errors++; $display("FAIL t6_sym_count got=%0d exp=4", sym_count); end
    endtask

    initial begin
        test_reset;
        test_positive;
        test_negative_and_threshold;
        test_short;
        test_saturation;
        test_reset_mid_window;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
